// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the frame-memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        REQ_TMPL = 1'b0,
        REQ_WIN  = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_T = 2'd1,
        OWN_W = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    localparam int DEFAULT_ROW_STRIDE = 20;

    function automatic req_id_t other_id(input req_id_t id);
        other_id = (id == REQ_TMPL) ? REQ_WIN : REQ_TMPL;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of {valid, requester id} tags that travels alongside each memory read
// so the returned word can be routed back to the requester that issued it.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_id,
    output logic pop_valid,
    output logic pop_id
);

    rd_tag_t [RD_LAT:0] pipe_r;

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= '{valid: push_valid, id: req_id_t'(push_id)};
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign pop_valid = pipe_r[RD_LAT].valid;
    assign pop_id    = pipe_r[RD_LAT].id;

endmodule

// File: rtl/mem_read_arbiter.sv
// Two-requester read scheduler for the frame memory with locked bursts and tagged return.
// Build option MEM_READ_ARBITER_TMPL_PRIO_EN: template requester always wins ties in IDLE.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int ROW_STRIDE = DEFAULT_ROW_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              t_req,
    input  logic              w_req,
    input  logic              t_lock,
    input  logic              w_lock,
    input  logic [6:0]        t_row,
    input  logic [6:0]        w_row,
    input  logic [6:0]        t_col,
    input  logic [6:0]        w_col,
    input  logic [ADDR_W-1:0] tmpl_base,
    input  logic [ADDR_W-1:0] win_base,
    output logic              t_gnt,
    output logic              w_gnt,
    output logic              t_valid,
    output logic              w_valid,
    output logic [DATA_W-1:0] t_data,
    output logic [DATA_W-1:0] w_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    req_id_t           last_r;
    req_id_t           tie_win_s;
    logic [ADDR_W-1:0] t_addr_s;
    logic [ADDR_W-1:0] w_addr_s;
    logic              pop_valid_s;
    logic              pop_id_s;

    // Linear address, deliberately wrapping modulo 2^ADDR_W.
    assign t_addr_s = tmpl_base + (ADDR_W'(t_row) * ADDR_W'(ROW_STRIDE)) + ADDR_W'(t_col);
    assign w_addr_s = win_base  + (ADDR_W'(w_row) * ADDR_W'(ROW_STRIDE)) + ADDR_W'(w_col);

`ifdef MEM_READ_ARBITER_TMPL_PRIO_EN
    assign tie_win_s = REQ_TMPL;
`else
    assign tie_win_s = other_id(last_r);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: lock sampled at the grant decides ownership for the next cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (t_gnt && t_lock) begin
                    state_nxt_s = OWN_T;
                end else if (w_gnt && w_lock) begin
                    state_nxt_s = OWN_W;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN_T: begin
                if (!t_req || !t_lock) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OWN_T;
                end
            end
            OWN_W: begin
                if (!w_req || !w_lock) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OWN_W;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant outputs: combinational from requests and state, at most one per cycle.
    always_comb begin
        t_gnt = 1'b0;
        w_gnt = 1'b0;
        case (state_r)
            IDLE: begin
                if (t_req && w_req) begin
                    if (tie_win_s == REQ_TMPL) begin
                        t_gnt = 1'b1;
                    end else begin
                        w_gnt = 1'b1;
                    end
                end else begin
                    t_gnt = t_req;
                    w_gnt = w_req;
                end
            end
            OWN_T:   t_gnt = t_req;
            OWN_W:   w_gnt = w_req;
            default: begin
                t_gnt = 1'b0;
                w_gnt = 1'b0;
            end
        endcase
    end

    // Round-robin pointer tracks the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= REQ_WIN;
        end else if (t_gnt) begin
            last_r <= REQ_TMPL;
        end else if (w_gnt) begin
            last_r <= REQ_WIN;
        end else begin
            last_r <= last_r;
        end
    end

    // Issue the granted read one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else if (t_gnt) begin
            mem_rd   <= 1'b1;
            mem_addr <= t_addr_s;
        end else if (w_gnt) begin
            mem_rd   <= 1'b1;
            mem_addr <= w_addr_s;
        end else begin
            mem_rd   <= 1'b0;
            mem_addr <= mem_addr;
        end
    end

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(t_gnt | w_gnt),
        .push_id   (w_gnt),
        .pop_valid (pop_valid_s),
        .pop_id    (pop_id_s)
    );

    // Route the captured word to its owner; the other data output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            w_valid <= 1'b0;
            t_data  <= '0;
            w_data  <= '0;
        end else begin
            t_valid <= pop_valid_s && (pop_id_s == REQ_TMPL);
            w_valid <= pop_valid_s && (pop_id_s == REQ_WIN);
            if (pop_valid_s && (pop_id_s == REQ_TMPL)) begin
                t_data <= mem_rdata;
            end else begin
                t_data <= t_data;
            end
            if (pop_valid_s && (pop_id_s == REQ_WIN)) begin
                w_data <= mem_rdata;
            end else begin
                w_data <= w_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: cycle table plus hand-written tie, lock, wrap and reset sequences.
module tb_mem_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic        t_req, w_req, t_lock, w_lock;
    logic [6:0]  t_row, w_row, t_col, w_col;
    logic [15:0] tmpl_base, win_base;
    logic        t_gnt, w_gnt, t_valid, w_valid, mem_rd;
    logic [31:0] t_data, w_data, mem_rdata;
    logic [15:0] mem_addr;
    logic [15:0] rdp0, rdp1;

    int checks = 0;
    int errors = 0;

`ifdef MEM_READ_ARBITER_TMPL_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam logic [31:0] DT = 32'hC0DE0217;  // word at template address 0x0217
    localparam logic [31:0] DW = 32'hC0DE012D;  // word at window address 0x012D

    mem_read_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2), .ROW_STRIDE(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_req(t_req), .w_req(w_req), .t_lock(t_lock), .w_lock(w_lock),
        .t_row(t_row), .w_row(w_row), .t_col(t_col), .w_col(w_col),
        .tmpl_base(tmpl_base), .win_base(win_base),
        .t_gnt(t_gnt), .w_gnt(w_gnt), .t_valid(t_valid), .w_valid(w_valid),
        .t_data(t_data), .w_data(w_data),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with two-cycle read latency; word = {0xC0DE, address}.
    always @(posedge clk) begin
        rdp0 <= mem_addr;
        rdp1 <= rdp0;
    end
    assign mem_rdata = {16'hC0DE, rdp1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic tr, input logic tl, input logic wr, input logic wl);
        @(negedge clk);
        t_req = tr; t_lock = tl; w_req = wr; w_lock = wl;
        #1;
    endtask

    typedef struct {
        logic        tr, tl, wr, wl;
        logic        tg, wg, rd;
        logic [15:0] addr;
        logic        tv, wv;
        logic [31:0] td, wd;
    } vec_t;

    vec_t vec [0:14];
    logic exp_tv [0:15];
    logic exp_wv [0:15];
    logic exp_t;

    initial begin
        // single window read, then a locked template pair with a blocked window request
        vec[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0, 32'h0,32'h0};
        vec[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,16'h0000, 1'b0,1'b0, 32'h0,32'h0};
        vec[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,16'h012D, 1'b0,1'b0, 32'h0,32'h0};
        vec[3]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b0, 32'h0,32'h0};
        vec[4]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b0, 32'h0,32'h0};
        vec[5]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b1, 32'h0,DW};
        vec[6]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b0, 32'h0,DW};
        vec[7]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h012D, 1'b0,1'b0, 32'h0,DW};
        vec[8]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,16'h0217, 1'b0,1'b0, 32'h0,DW};
        vec[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,16'h0217, 1'b0,1'b0, 32'h0,DW};
        vec[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,16'h012D, 1'b0,1'b0, 32'h0,DW};
        vec[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b1,1'b0, DT,DW};
        vec[12] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b1,1'b0, DT,DW};
        vec[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b1, DT,DW};
        vec[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'h012D, 1'b0,1'b0, DT,DW};

        rst_n = 1'b0;
        t_req = 1'b0; w_req = 1'b0; t_lock = 1'b0; w_lock = 1'b0;
        tmpl_base = 16'h0200; t_row = 7'd1; t_col = 7'd3;   // -> 0x0217
        win_base  = 16'h0100; w_row = 7'd2; w_col = 7'd5;   // -> 0x012D
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vec[i].tr, vec[i].tl, vec[i].wr, vec[i].wl);
            chk($sformatf("v%0d_t_gnt", i),   32'(t_gnt),    32'(vec[i].tg));
            chk($sformatf("v%0d_w_gnt", i),   32'(w_gnt),    32'(vec[i].wg));
            chk($sformatf("v%0d_mem_rd", i),  32'(mem_rd),   32'(vec[i].rd));
            chk($sformatf("v%0d_mem_addr", i),32'(mem_addr), 32'(vec[i].addr));
            chk($sformatf("v%0d_t_valid", i), 32'(t_valid),  32'(vec[i].tv));
            chk($sformatf("v%0d_w_valid", i), 32'(w_valid),  32'(vec[i].wv));
            chk($sformatf("v%0d_t_data", i),  t_data,        vec[i].td);
            chk($sformatf("v%0d_w_data", i),  w_data,        vec[i].wd);
        end

        // continuous tie: last grant was W, so T leads; returns follow grant order
        for (int k = 0; k < 16; k++) begin
            exp_tv[k] = 1'b0;
            exp_wv[k] = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            drive(k < 4, 1'b0, k < 4, 1'b0);
            if (k < 4) begin
                exp_t = PRIO ? 1'b1 : ((k % 2) == 0);
                chk($sformatf("tie%0d_t_gnt", k), 32'(t_gnt), 32'(exp_t));
                chk($sformatf("tie%0d_w_gnt", k), 32'(w_gnt), 32'(!exp_t));
                exp_tv[k+4] = exp_t;
                exp_wv[k+4] = !exp_t;
            end
            chk($sformatf("tie%0d_t_valid", k), 32'(t_valid), 32'(exp_tv[k]));
            chk($sformatf("tie%0d_w_valid", k), 32'(w_valid), 32'(exp_wv[k]));
            if (exp_tv[k]) chk($sformatf("tie%0d_t_data", k), t_data, DT);
            if (exp_wv[k]) chk($sformatf("tie%0d_w_data", k), w_data, DW);
        end

        // locked window burst of four while template keeps requesting
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("lock0_w_gnt", 32'(w_gnt), 32'd1);
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, k < 3);
            chk($sformatf("lock%0d_w_gnt", k), 32'(w_gnt), 32'd1);
            chk($sformatf("lock%0d_t_gnt", k), 32'(t_gnt), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("lock4_t_gnt", 32'(t_gnt), 32'd1);
        chk("lock4_w_gnt", 32'(w_gnt), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // address wrap: 0xFFFF + 0*20 + 1
        tmpl_base = 16'hFFFF; t_row = 7'd0; t_col = 7'd1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_t_gnt", 32'(t_gnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_mem_rd", 32'(mem_rd), 32'd1);
        chk("wrap_mem_addr", 32'(mem_addr), 32'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_t_valid", 32'(t_valid), 32'd1);
        chk("wrap_t_data", t_data, 32'hC0DE0000);
        tmpl_base = 16'h0200; t_row = 7'd1; t_col = 7'd3;

        // reset one cycle after two grants: in-flight reads are dropped
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_t_gnt", 32'(t_gnt), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_pre_w_gnt", 32'(w_gnt), 32'd1);
        @(negedge clk);
        w_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_t_data", t_data, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_gnts", {30'd0, t_gnt, w_gnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("post_rst%0d_valids", k), {30'd0, t_valid, w_valid}, 32'd0);
            chk($sformatf("post_rst%0d_mem_rd", k), 32'(mem_rd), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_tie_t_gnt", 32'(t_gnt), 32'd1);
        chk("post_rst_tie_w_gnt", 32'(w_gnt), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
